// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
//   Time-multiplexed driver for a bank of DIGITS common-anode 7-segment
//   digits. A hex value is double-buffered: load fills a pending buffer, and
//   the displayed (active) value only changes at a frame wrap, so a frame
//   never shows a mix of old and new digits. Outputs are active-low and
//   registered.
//
//   Optional feature (macro SEG7_SCAN_BLINK_EN): adds parameter BLINK_FRAMES
//   and input blink_i. A phase bit toggles every BLINK_FRAMES wraps. While
//   the phase is 1, digits with blink_i set are blanked, with the anode kept
//   driven.
//
// Parameters
//   DIGITS   number of digits scanned (1..16)
//   SCAN_DIV clk cycles each digit stays lit (>= 1)
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   load     one-cycle strobe; captures value_i/dp_i
//   value_i  hex nibbles, nibble 0 = rightmost digit
//   dp_i     decimal-point request per digit (1 = lit)
//   en_i     per-digit enable, live (0 = dark)
//   lzs_i    leading-zero suppression enable, live
//   blink_i  per-digit blink request (SEG7_SCAN_BLINK_EN only)
//   seg_o    active-low segments {g,f,e,d,c,b,a}
//   dp_o     active-low decimal point
//   an_o     active-low one-hot anode select
//   frame_o  one-cycle pulse after the scan wraps to digit 0
module seg7_scan_mux #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 1000
`ifdef SEG7_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     en_i,
  input  logic                  lzs_i,
`ifdef SEG7_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink_i,
`endif
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic                  frame_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [PW-1:0]            presc_q, presc_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     tick, wrap;

  logic [DIGITS-1:0][3:0]   act_val_q, act_val_d;
  logic [DIGITS-1:0]        act_dp_q, act_dp_d;
  logic [DIGITS-1:0][3:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]        pend_dp_q, pend_dp_d;
  logic                     pend_vld_q, pend_vld_d;

  logic [6:0]               seg_q, seg_d;
  logic                     dp_q, dp_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic                     frame_q;

  logic [DIGITS-1:0]        zero_up;   // nibbles i..DIGITS-1 of active all zero
  logic                     dark, lz_blank, blink_blank, blank;

  // Scan timing
  assign tick = (presc_q == PRESC_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
  end

  // Double buffer. A load coinciding with the wrap tick bypasses the pending
  // buffer so it is shown in the frame that starts right there; any older
  // pending value is dropped.
  always_comb begin
    act_val_d  = act_val_q;
    act_dp_d   = act_dp_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (wrap) begin
      if (load) begin
        act_val_d  = value_i;
        act_dp_d   = dp_i;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        act_val_d  = pend_val_q;
        act_dp_d   = pend_dp_q;
        pend_vld_d = 1'b0;
      end
    end else if (load) begin
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
      pend_vld_d = 1'b1;
    end
  end

  // Leading-zero run, scanned from the most significant digit down
  always_comb begin
    logic run;
    run     = 1'b1;
    zero_up = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run        = run && (act_val_q[i] == 4'h0);
      zero_up[i] = run;
    end
  end

`ifdef SEG7_SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
  logic [BW-1:0] blink_cnt_q;
  logic          blink_ph_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_q <= '0;
        blink_ph_q  <= ~blink_ph_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_blank = blink_ph_q && blink_i[idx_q];
`else
  assign blink_blank = 1'b0;
`endif

  // Digit 0 is never suppressed, so a zero value still shows one "0".
  assign dark     = !en_i[idx_q];
  assign lz_blank = lzs_i && (idx_q != '0) && zero_up[idx_q];
  assign blank    = dark || lz_blank || blink_blank;

  always_comb begin
    an_d  = dark  ? '1    : ~(DIGITS'(1) << idx_q);
    seg_d = blank ? 7'h7F : hex7(act_val_q[idx_q]);
    dp_d  = blank ? 1'b1  : ~act_dp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      act_val_q  <= '0;
      act_dp_q   <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      an_q       <= '1;
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dp_q   <= act_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= wrap;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Parametrised, time-multiplexed driver for a bank of DIGITS common-anode 7-segment digits.
- Holds a double-buffered hex value and scans one digit per SCAN_DIV clocks.
- Drives active-low segment, decimal-point and anode lines.
- Supports leading-zero suppression, per-digit enable and tear-free updates at frame boundaries.
- Sits between CPU-visible display registers and the board's shared segment bus.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 1..16.
- SCAN_DIV, 1000, clk cycles each digit stays lit; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- load  input  1  one-cycle strobe; captures value_i and dp_i into the pending buffer.
- value_i  input  4*DIGITS  hex nibbles; nibble 0 ([3:0]) is the rightmost, least-significant digit.
- dp_i  input  DIGITS  decimal-point request per digit (1 = lit).
- en_i  input  DIGITS  per-digit enable (0 = digit dark); sampled live, not buffered.
- lzs_i  input  1  leading-zero suppression enable; sampled live.
- seg_o  output  7  active-low segments {g,f,e,d,c,b,a}.
- dp_o  output  1  active-low decimal point.
- an_o  output  DIGITS  active-low one-hot anode select.
- frame_o  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Reset values:
  - seg_o=7'h7F, dp_o=1, an_o=all ones, frame_o=0.
  - Prescaler=0, digit index=0.
  - Active value=0, active dp=0, pending buffer=0, pending-valid=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1. A tick is prescaler==SCAN_DIV-1; the prescaler then returns to 0.
  - With SCAN_DIV=1, every cycle is a tick.
- Digit index advance, on each tick:
  - idx<DIGITS-1: idx increments.
  - idx==DIGITS-1: idx goes to 0 and frame_o pulses on the next cycle.
  - With DIGITS=1, every tick is a wrap.
- Buffering:
  - load writes the pending buffer and sets pending-valid. A second load before the wrap overwrites the pending buffer (last write wins).
  - At a wrap tick with pending-valid set: active <= pending and pending-valid is cleared.
  - load on the same cycle as a wrap tick: value_i and dp_i go directly into active and pending-valid is cleared. The older pending value is discarded.
  - The active value never changes mid-frame, so the display never tears.
- Hex encoding, code for 0..F:
  - 0-7: 40, 79, 24, 30, 19, 12, 02, 78.
  - 8-F: 00, 10, 08, 03, 46, 21, 06, 0E.
  - Blank is 7F.
- Blanking, for digit i:
  - If en_i[i]=0: digit is dark, with seg 7F, dp 1 and an bit 1.
  - If lzs_i=1, i>0, and nibbles i..DIGITS-1 of active are all zero: seg 7F, dp 1, anode still driven.
  - Digit 0 is never suppressed.
- Output timing:
  - seg_o, dp_o and an_o are registered. They reflect the current idx one cycle after idx changes.
  - an_o has exactly one zero bit, or all ones when the selected digit is disabled.
  - dp_o=~active_dp[idx] when the digit is not blanked.
- rst mid-frame returns all state to reset values on the next edge. Any pending load is lost.

Optional Feature:
- Macro: SEG7_SCAN_BLINK_EN.
- When defined:
  - Adds parameter BLINK_FRAMES (default 64) and input blink_i[DIGITS-1:0].
  - A blink phase bit toggles every BLINK_FRAMES wraps; it resets to 0.
  - While phase=1, digits with blink_i set show seg 7F with dp 1, and their anode is still driven.
- When undefined: no port, no counter, and behaviour is exactly as above.

Test Plan (DIGITS=4, SCAN_DIV=4):
- Reset, then run 40 cycles -> an_o cycles E,D,B,7 with each value held 4 cycles. Digit 0 shows seg 40; digits 1-3 show 40 (lzs_i=0, en_i=F). frame_o pulses once every 16 cycles.
- load value_i=16'h12AF, dp_i=4'b0100 mid-frame -> display unchanged until the next frame_o. Next frame: digit0=0E, digit1=08, digit2=24 with dp_o=0, digit3=79.
- lzs_i=1 with active 16'h0050 -> digits 3 and 2 show 7F while their anodes are still active; digit1=12, digit0=40. Active 16'h0000 -> only digit0 shows 40.
- en_i=4'b1010 -> an_o never asserts bits 0 or 2. Slots 0 and 2 show an_o=F, seg_o=7F.
- Two loads (16'h1111 then 16'h2222) within one frame -> 2222 is shown. A load of 16'h3333 exactly on the wrap tick -> 3333 is shown in the frame that starts there.
- rst asserted mid-frame with a load pending -> the next cycle shows reset values. After release, the display shows 0000 and the pending value never appears.
